// File: rtl/wb_stage.sv
// Writeback stage: retire buffer feeding the register-file write ports, plus jump redirect/flush and halt.
// Optional feature: define WB_BYPASS_EN to let an entry commit in its push cycle when the buffer is empty.
module wb_stage #(
  parameter int REGI_BITS    = 4,
  parameter int VECT_BITS    = 2,
  parameter int REGI_SIZE    = 16,
  parameter int VECT_SIZE    = 8,
  parameter int ELEM_SIZE    = 8,
  parameter int FIFO_DEPTH   = 2,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           mem_valid_i,
  output logic                           mem_ready_o,
  input  logic                           int_we_i,
  input  logic [REGI_BITS-1:0]           int_dest_i,
  input  logic [REGI_SIZE-1:0]           int_data_i,
  input  logic                           vec_we_i,
  input  logic [VECT_BITS-1:0]           vec_dest_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] vec_data_i,
  input  logic                           jump_en_i,
  input  logic [9:0]                     jump_addr_i,
  input  logic                           end_i,
  input  logic                           rf_ready_i,
  output logic                           int_we_o,
  output logic [REGI_BITS-1:0]           int_dest_o,
  output logic [REGI_SIZE-1:0]           int_wd_o,
  output logic                           vec_we_o,
  output logic [VECT_BITS-1:0]           vec_dest_o,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] vec_wd_o,
  output logic                           redirect_o,
  output logic [REGI_SIZE-1:0]           redirect_pc_o,
  output logic                           flush_o,
  output logic                           halted_o
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int VEC_W = ELEM_SIZE * VECT_SIZE;
  localparam int FC_W  = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef struct packed {
    logic                 int_we;
    logic [REGI_BITS-1:0] int_dest;
    logic [REGI_SIZE-1:0] int_data;
    logic                 vec_we;
    logic [VECT_BITS-1:0] vec_dest;
    logic [VEC_W-1:0]     vec_data;
    logic                 jump_en;
    logic [9:0]           jump_addr;
    logic                 end_f;
  } entry_t;

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

  entry_t           fifo_mem [FIFO_DEPTH];
  entry_t           in_entry, cm_entry;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  state_t           state_q, state_d;
  logic             alive_q;
  logic             empty, full, accept, push, pop, bypass, commit;

  assign in_entry = '{int_we: int_we_i, int_dest: int_dest_i, int_data: int_data_i,
                      vec_we: vec_we_i, vec_dest: vec_dest_i, vec_data: vec_data_i,
                      jump_en: jump_en_i, jump_addr: jump_addr_i, end_f: end_i};

  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  // alive_q keeps ready low until the first clock after reset release
  assign mem_ready_o = alive_q & !full & (state_q != S_HALT);
  assign accept      = mem_valid_i & mem_ready_o;

`ifdef WB_BYPASS_EN
  assign bypass = accept & empty & rf_ready_i & (state_q == S_RUN);
`else
  assign bypass = 1'b0;
`endif

  assign pop      = !empty & rf_ready_i & (state_q == S_RUN);
  assign commit   = pop | bypass;
  assign cm_entry = bypass ? in_entry : fifo_mem[rd_ptr_q];
  // Entries accepted while flushing are wrong-path and never stored
  assign push     = accept & (state_q == S_RUN) & !bypass;

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    case (state_q)
      S_RUN: begin
        if (commit && cm_entry.jump_en) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
          fcnt_d   = FC_W'(FLUSH_CYCLES);
          state_d  = S_FLUSH;
        end
        if (commit && cm_entry.end_f) state_d = S_HALT;
      end
      S_FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = S_RUN;
        end else if (accept) begin
          fcnt_d = fcnt_q - 1'b1;
          if (fcnt_q == FC_W'(1)) state_d = S_RUN;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_RUN;
      fcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      alive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      alive_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= in_entry;
  end

  // Dest/data are forced to zero unless their strobe is active
  assign int_we_o      = commit & cm_entry.int_we;
  assign int_dest_o    = int_we_o ? cm_entry.int_dest : '0;
  assign int_wd_o      = int_we_o ? cm_entry.int_data : '0;
  assign vec_we_o      = commit & cm_entry.vec_we;
  assign vec_dest_o    = vec_we_o ? cm_entry.vec_dest : '0;
  assign vec_wd_o      = vec_we_o ? cm_entry.vec_data : '0;
  assign redirect_o    = commit & cm_entry.jump_en & (state_q == S_RUN);
  assign redirect_pc_o = redirect_o ? REGI_SIZE'(cm_entry.jump_addr) : '0;
  assign flush_o       = (state_q == S_FLUSH);
  assign halted_o      = (state_q == S_HALT);
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage (default build, WB_BYPASS_EN undefined).
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid, mem_ready;
  logic        iwe, vwe, jen, en, rf_ready;
  logic [3:0]  idst;
  logic [15:0] idat;
  logic [1:0]  vdst;
  logic [63:0] vdat;
  logic [9:0]  jaddr;
  logic        int_we_o, vec_we_o, redirect_o, flush_o, halted_o;
  logic [3:0]  int_dest_o;
  logic [15:0] int_wd_o, redirect_pc_o;
  logic [1:0]  vec_dest_o;
  logic [63:0] vec_wd_o;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk_i(clk), .rst_i(rst_n), .mem_valid_i(mem_valid), .mem_ready_o(mem_ready),
    .int_we_i(iwe), .int_dest_i(idst), .int_data_i(idat),
    .vec_we_i(vwe), .vec_dest_i(vdst), .vec_data_i(vdat),
    .jump_en_i(jen), .jump_addr_i(jaddr), .end_i(en), .rf_ready_i(rf_ready),
    .int_we_o(int_we_o), .int_dest_o(int_dest_o), .int_wd_o(int_wd_o),
    .vec_we_o(vec_we_o), .vec_dest_o(vec_dest_o), .vec_wd_o(vec_wd_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .flush_o(flush_o), .halted_o(halted_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
    $display("check %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic a_iwe, input logic [3:0] a_idst,
                       input logic [15:0] a_idat, input logic a_vwe, input logic [1:0] a_vdst,
                       input logic [63:0] a_vdat, input logic a_jen, input logic [9:0] a_ja,
                       input logic a_en);
    mem_valid = v; iwe = a_iwe; idst = a_idst; idat = a_idat;
    vwe = a_vwe; vdst = a_vdst; vdat = a_vdat; jen = a_jen; jaddr = a_ja; en = a_en;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 2'd0, 64'd0, 1'b0, 10'd0, 1'b0);
  endtask

  task automatic push_int(input logic [3:0] d, input logic [15:0] x);
    drive(1'b1, 1'b1, d, x, 1'b0, 2'd0, 64'd0, 1'b0, 10'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    rf_ready = 1'b1;
    // Reset state
    tick();
    settle();
    chk("rst_ready", mem_ready, 0);
    chk("rst_int_we", int_we_o, 0);
    chk("rst_halted", halted_o, 0);
    chk("rst_flush", flush_o, 0);
    rst_n = 1'b1;
    settle();
    chk("rel_ready_early", mem_ready, 0);
    tick();
    settle();
    chk("rel_ready", mem_ready, 1);

    // Basic int write, latency 1
    push_int(4'd3, 16'h00A5);
    settle();
    chk("lat_no_commit", int_we_o, 0);
    tick();
    idle();
    settle();
    chk("int_we", int_we_o, 1);
    chk("int_dest", int_dest_o, 3);
    chk("int_wd", int_wd_o, 16'h00A5);
    chk("int_vec_we", vec_we_o, 0);
    tick();

    // Back-pressure: buffer fills, then drains in order
    rf_ready = 1'b0;
    push_int(4'd1, 16'h0011);
    settle();
    chk("bp_ready0", mem_ready, 1);
    tick();
    push_int(4'd2, 16'h0022);
    tick();
    push_int(4'd4, 16'h0044);
    settle();
    chk("bp_full_ready", mem_ready, 0);
    chk("bp_hold_we", int_we_o, 0);
    tick();
    rf_ready = 1'b1;
    settle();
    chk("bp_ready_rf", mem_ready, 0);
    chk("bp_c1_dest", int_dest_o, 1);
    chk("bp_c1_wd", int_wd_o, 16'h0011);
    tick();
    settle();
    chk("bp_ready_again", mem_ready, 1);
    chk("bp_c2_dest", int_dest_o, 2);
    tick();
    idle();
    settle();
    chk("bp_c3_dest", int_dest_o, 4);
    chk("bp_c3_wd", int_wd_o, 16'h0044);
    tick();
    settle();
    chk("bp_empty_we", int_we_o, 0);

    // Reset mid-stream with two entries buffered
    rf_ready = 1'b0;
    push_int(4'd6, 16'h0066);
    tick();
    push_int(4'd7, 16'h0077);
    tick();
    idle();
    rst_n = 1'b0;
    rf_ready = 1'b1;
    #1;
    chk("mid_rst_we", int_we_o, 0);
    chk("mid_rst_ready", mem_ready, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    settle();
    chk("mid_rst_empty", int_we_o, 0);
    chk("mid_rst_ready1", mem_ready, 1);

    // Dual write and a nop with stray dest/data
    drive(1'b1, 1'b1, 4'd2, 16'h1234, 1'b1, 2'd3, 64'h0102030405060708, 1'b0, 10'd0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 4'd9, 16'hFFFF, 1'b0, 2'd3, 64'hDEAD, 1'b0, 10'd0, 1'b0);
    settle();
    chk("dual_int_we", int_we_o, 1);
    chk("dual_vec_we", vec_we_o, 1);
    chk("dual_int_wd", int_wd_o, 16'h1234);
    chk("dual_vec_dest", vec_dest_o, 3);
    chk("dual_vec_wd", vec_wd_o, 64'h0102030405060708);
    tick();
    idle();
    settle();
    chk("nop_int_we", int_we_o, 0);
    chk("nop_int_dest", int_dest_o, 0);
    chk("nop_vec_dest", vec_dest_o, 0);
    chk("nop_vec_wd", vec_wd_o, 0);
    tick();

    // Jump: write + redirect, then three wrong-path entries dropped
    drive(1'b1, 1'b1, 4'd15, 16'hBEEF, 1'b0, 2'd0, 64'd0, 1'b1, 10'h020, 1'b0);
    tick();
    idle();
    settle();
    chk("jmp_int_we", int_we_o, 1);
    chk("jmp_int_dest", int_dest_o, 15);
    chk("jmp_int_wd", int_wd_o, 16'hBEEF);
    chk("jmp_redirect", redirect_o, 1);
    chk("jmp_pc", redirect_pc_o, 16'h0020);
    tick();
    drive(1'b1, 1'b1, 4'd5, 16'h0005, 1'b0, 2'd0, 64'd0, 1'b1, 10'h111, 1'b0);
    settle();
    chk("fl1_flush", flush_o, 1);
    chk("fl1_ready", mem_ready, 1);
    chk("fl1_redirect", redirect_o, 0);
    tick();
    drive(1'b1, 1'b1, 4'd6, 16'h0006, 1'b0, 2'd0, 64'd0, 1'b0, 10'd0, 1'b1);
    settle();
    chk("fl2_flush", flush_o, 1);
    chk("fl2_we", int_we_o, 0);
    tick();
    push_int(4'd7, 16'h0007);
    settle();
    chk("fl3_flush", flush_o, 1);
    chk("fl3_we", int_we_o, 0);
    tick();
    push_int(4'd9, 16'h0909);
    settle();
    chk("fl_done", flush_o, 0);
    chk("fl_done_we", int_we_o, 0);
    tick();
    idle();
    settle();
    chk("post_fl_dest", int_dest_o, 9);
    chk("post_fl_wd", int_wd_o, 16'h0909);
    chk("post_fl_redirect", redirect_o, 0);
    chk("post_fl_halted", halted_o, 0);
    tick();

    // End: its write happens, then halt blocks everything
    drive(1'b1, 1'b1, 4'd8, 16'h0808, 1'b0, 2'd0, 64'd0, 1'b0, 10'd0, 1'b1);
    tick();
    push_int(4'd10, 16'h0A0A);
    settle();
    chk("end_we", int_we_o, 1);
    chk("end_dest", int_dest_o, 8);
    chk("end_not_yet", halted_o, 0);
    tick();
    settle();
    chk("halt_halted", halted_o, 1);
    chk("halt_ready", mem_ready, 0);
    chk("halt_we", int_we_o, 0);
    tick();
    tick();
    idle();
    settle();
    chk("halt_stay", halted_o, 1);
    chk("halt_we2", int_we_o, 0);

    // Jump and end in one entry: redirect, then halt
    do_reset();
    settle();
    chk("rst2_halted", halted_o, 0);
    drive(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 2'd0, 64'd0, 1'b1, 10'h3FF, 1'b1);
    tick();
    idle();
    settle();
    chk("je_redirect", redirect_o, 1);
    chk("je_pc", redirect_pc_o, 16'h03FF);
    tick();
    settle();
    chk("je_halted", halted_o, 1);
    chk("je_flush", flush_o, 0);
    chk("je_redirect_off", redirect_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
